// File: rtl/rol_16b_4b_seq.sv
// Sequential 16-bit rotate-left log-shifter: one stage per cycle, valid/ready on both sides.
// Optional build macro ROL_SEQ_EARLY_DONE_EN skips trailing stages whose amount bits are zero.
module rol_16b_4b_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [1:0]  stg, stg_nx;
  logic [15:0] data, data_nx, rot;
  logic [3:0]  amt, amt_nx;
  logic        unused_b;

  assign unused_b  = ^B[15:4];
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign out       = data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      stg   <= 2'd0;
      data  <= 16'h0000;
      amt   <= 4'd0;
    end else begin
      state <= state_nx;
      stg   <= stg_nx;
      data  <= data_nx;
      amt   <= amt_nx;
    end
  end

  // Stage s rotates left by 2^s.
  always_comb begin
    rot = data;
    case (stg)
      2'd0:    rot = {data[14:0], data[15]};
      2'd1:    rot = {data[13:0], data[15:14]};
      2'd2:    rot = {data[11:0], data[15:12]};
      default: rot = {data[7:0],  data[15:8]};
    endcase
  end

`ifdef ROL_SEQ_EARLY_DONE_EN
  logic tail_zero;

  always_comb begin
    tail_zero = 1'b1;
    case (stg)
      2'd0:    tail_zero = (amt[3:1] == 3'b000);
      2'd1:    tail_zero = (amt[3:2] == 2'b00);
      2'd2:    tail_zero = !amt[3];
      default: tail_zero = 1'b1;
    endcase
  end
`endif

  always_comb begin
    state_nx = state;
    stg_nx   = stg;
    data_nx  = data;
    amt_nx   = amt;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          data_nx  = A;
          amt_nx   = B[3:0];
          stg_nx   = 2'd0;
          state_nx = RUN;
`ifdef ROL_SEQ_EARLY_DONE_EN
          if (B[3:0] == 4'd0)
            state_nx = DONE;
`endif
        end
      end
      RUN: begin
        data_nx = amt[stg] ? rot : data;
        stg_nx  = stg + 2'd1;
        if (stg == 2'd3)
          state_nx = DONE;
`ifdef ROL_SEQ_EARLY_DONE_EN
        if (tail_zero)
          state_nx = DONE;
`endif
      end
      DONE: begin
        if (out_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rol_16b_4b_seq.sv
// Scoreboard bench for rol_16b_4b_seq: the driver queues expected results, a monitor
// pops and compares on every output handshake and checks the first-valid latency.
module tb_rol_16b_4b_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] op_a = 16'h0000;
  logic [15:0] op_b = 16'h0000;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        ready_force = 1'b1;
  logic        rand_ready = 1'b0;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] exp;
    int          n;
    int          acc;
    int          lat;
  } item_t;

  item_t sb[$];

  rol_16b_4b_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(op_a), .B(op_b), .out_valid(out_valid), .out_ready(out_ready), .out(out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end
  end

  function automatic logic [15:0] rol(input logic [15:0] a, input int n);
    logic [31:0] w;
    w = {a, a} << n;
    return w[31:16];
  endfunction

  function automatic logic [15:0] ror(input logic [15:0] r, input int n);
    logic [31:0] w;
    w = {r, r} >> n;
    return w[15:0];
  endfunction

  function automatic int exp_lat(input int n);
`ifdef ROL_SEQ_EARLY_DONE_EN
    if (n == 0) return 1;
    if (n >= 8) return 5;
    if (n >= 4) return 4;
    if (n >= 2) return 3;
    return 2;
`else
    return 5;
`endif
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp);
    int    waited;
    item_t it;
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    op_a = a;
    op_b = b;
    #2;
    while (!in_ready && waited < 300) begin
      @(negedge clk);
      #2;
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: in_ready stuck at 0 for A=%h", a);
      in_valid = 1'b0;
      return;
    end
    it.a   = a;
    it.exp = exp;
    it.n   = int'(b[3:0]);
    it.acc = cyc;
    it.lat = exp_lat(int'(b[3:0]));
    sb.push_back(it);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (sb.size() != 0 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d pending, want 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: compare on handshake; latency is measured at the first cycle out_valid is seen.
  initial begin
    bit    seen;
    item_t it;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        seen = 1'b0;
      end else if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_out: got out_valid=1 out=%h, want no result", out);
        end else begin
          if (!seen) begin
            seen = 1'b1;
            check_int("latency", cyc - sb[0].acc, sb[0].lat);
          end
          if (out_ready) begin
            it = sb.pop_front();
            check("result", out, it.exp);
            check("ror_back", ror(out, it.n), it.a);
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got no end of test, want $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;

    repeat (3) @(negedge clk);
    #2 check("in_ready_in_reset", {15'd0, in_ready}, 16'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    #2;
    check("rst_out_valid", {15'd0, out_valid}, 16'd0);
    check("rst_out", out, 16'h0000);
    check("rst_in_ready", {15'd0, in_ready}, 16'd1);

    apply_stimulus(16'h8001, 16'h0001, 16'h0003);
    apply_stimulus(16'h1234, 16'h0004, 16'h2341);
    apply_stimulus(16'hABCD, 16'h0008, 16'hCDAB);
    apply_stimulus(16'h0001, 16'h000F, 16'h8000);
    apply_stimulus(16'h5A5A, 16'hFFF0, 16'h5A5A);
    apply_stimulus(16'h4001, 16'h0002, 16'h0005);
    drain();

    // Backpressure: hold the result for three cycles while a stray request is offered.
    ready_force = 1'b0;
    apply_stimulus(16'h00F0, 16'h0004, 16'h0F00);
    w = 0;
    do begin
      @(negedge clk);
      #2;
      w++;
    end while (!out_valid && w < 50);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #2;
      end
      check("bp_out_valid", {15'd0, out_valid}, 16'd1);
      check("bp_out", out, 16'h0F00);
      check("bp_in_ready", {15'd0, in_ready}, 16'd0);
      if (i == 0) begin
        in_valid = 1'b1;
        op_a = 16'hFFFF;
        op_b = 16'h0001;
      end
    end
    in_valid = 1'b0;
    ready_force = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2;
    check("bp_release_in_ready", {15'd0, in_ready}, 16'd1);
    check("bp_release_out_valid", {15'd0, out_valid}, 16'd0);
    drain();

    // Reset during RUN stage 2 aborts the operation.
    apply_stimulus(16'h1234, 16'h0007, 16'h1A09);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    #2;
    check("abort_out_valid", {15'd0, out_valid}, 16'd0);
    check("abort_out", out, 16'h0000);
    check("abort_in_ready", {15'd0, in_ready}, 16'd1);
    apply_stimulus(16'h0003, 16'h0002, 16'h000C);
    drain();

    // Reset wins over a coincident request.
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    op_a = 16'h1234;
    op_b = 16'h0001;
    #2 check("prio_in_ready", {15'd0, in_ready}, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    #2;
    check("prio_idle_in_ready", {15'd0, in_ready}, 16'd1);
    check("prio_out_valid", {15'd0, out_valid}, 16'd0);
    repeat (8) @(negedge clk);

    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      apply_stimulus(ra, rb, rol(ra, int'(rb[3:0])));
    end
    drain();
    rand_ready = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
